// File: rtl/misc_v_pkg.sv
// Shared definitions for the pipeline hazard controller: the EX-stage argument
// mux select encodings and the controller state enum.
package misc_v_pkg;

  localparam logic [1:0] FWD_ALU_MEM = 2'b00;  // ALU result now sitting in MEM
  localparam logic [1:0] FWD_WB      = 2'b01;  // writeback value
  localparam logic [1:0] FWD_REG     = 2'b10;  // register-file argument
  localparam logic [1:0] FWD_ZERO    = 2'b11;  // constant zero, never selected

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_e;

  // Producer hit vector per source: [0] = EX, [1] = MEM, [2] = WB.
  // The youngest producer (EX) wins over MEM; WB is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [2:0] hit);
    if (hit[0])      return FWD_ALU_MEM;
    else if (hit[1]) return FWD_WB;
    else             return FWD_REG;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_match.sv
// hazard_match: compares one ID-stage source register against one producer
// stage. Register 0 is hardwired to zero, so it never creates a dependency.
module hazard_match #(
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] src,
  input  logic              src_use,
  input  logic [REG_AW-1:0] rd,
  input  logic              regwrite,
  output logic              hit
);

  assign hit = src_use & regwrite & (rd == src) & (rd != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: forwarding selects, load-use stall, branch flush and a
// saturating stall counter for a 5-stage pipeline.
// Build option: define HAZARD_FORWARD_EN to compile in operand forwarding;
// without it the selects stay on the register file and the block stalls on
// any EX/MEM/WB dependency instead.
module pipeline_hazard_ctrl
  import misc_v_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  input  logic              branch_taken,
  output logic [1:0]        mux1select,
  output logic [1:0]        mux2select,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int NSRC = 2;  // [0] = rs1, [1] = rs2
  localparam int NSTG = 3;  // [0] = EX, [1] = MEM, [2] = WB

  logic [NSRC-1:0][REG_AW-1:0] src;
  logic [NSRC-1:0]             src_use;
  logic [NSTG-1:0][REG_AW-1:0] prd;
  logic [NSTG-1:0]             pwe;
  logic [NSRC-1:0][NSTG-1:0]   hit;

  assign src     = {id_rs2, id_rs1};
  assign src_use = {id_use_rs2, id_use_rs1};
  assign prd     = {wb_rd, mem_rd, ex_rd};
  assign pwe     = {wb_regwrite, mem_regwrite, ex_regwrite};

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    for (genvar p = 0; p < NSTG; p++) begin : g_stg
      hazard_match #(.REG_AW(REG_AW)) u_match (
        .src      (src[s]),
        .src_use  (src_use[s]),
        .rd       (prd[p]),
        .regwrite (pwe[p]),
        .hit      (hit[s][p])
      );
    end
  end

  hz_state_e  state, state_n;
  logic       hazard;
  logic [1:0] sel1_n, sel2_n;

`ifdef HAZARD_FORWARD_EN
  // Only a load in EX cannot be forwarded. The bubble loaded by the first
  // stall cycle resolves it, so STALL never re-arms; in FLUSH the ID slot is
  // the squashed one and cannot raise a hazard either.
  assign hazard = ex_memread & (hit[0][0] | hit[1][0]) & (state == ST_RUN);
  assign sel1_n = fwd_sel(hit[0]);
  assign sel2_n = fwd_sel(hit[1]);

  logic unused_wb;
  assign unused_wb = hit[0][2] | hit[1][2];
`else
  // No forwarding paths: wait until every producer has retired.
  assign hazard = (|hit) & (state != ST_FLUSH);
  assign sel1_n = FWD_REG;
  assign sel2_n = FWD_REG;

  logic unused_memread;
  assign unused_memread = ex_memread;
`endif

  // Pipeline control: a taken branch overrides and cancels any stall.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    if (reset) begin
      if (branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (hazard) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
      end
    end
  end

  // Next-state: branch wins from any state; FLUSH lasts a single cycle.
  always_comb begin
    state_n = ST_RUN;
    if (branch_taken) begin
      state_n = ST_FLUSH;
    end else begin
      case (state)
        ST_RUN, ST_STALL: state_n = hazard ? ST_STALL : ST_RUN;
        ST_FLUSH:         state_n = ST_RUN;
        default:          state_n = ST_RUN;
      endcase
    end
  end

  // State, selects registered as the ID instruction enters EX, stall counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_RUN;
      mux1select   <= FWD_REG;
      mux2select   <= FWD_REG;
      stall_cycles <= '0;
    end else begin
      state      <= state_n;
      mux1select <= idex_bubble ? FWD_REG : sel1_n;
      mux2select <= idex_bubble ? FWD_REG : sel2_n;
      if (pc_stall && !(&stall_cycles))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
